rv32_fetch: RTL and testbench

// Instruction fetch stage of the RV32 pipeline; feeds rv32_decode.
// - Owns the PC and drives the instruction bus with a valid/ready handshake.
// - Applies static branch prediction on the fetched word.
// - Registers one {pc, instr, next_pc, predicted-taken, exception} bundle per cycle.
// - Absorbs hazard-unit stalls, flushes and redirects (mispredict, trap, mret).

---
 rtl/rv32_fetch.sv | 193 +++++++++++++++++++
 tb/tb_rv32_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch.sv
// rtl/rv32_fetch.sv - RV32 instruction fetch stage with static branch prediction
module rv32_fetch #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter bit          BRANCH_PREDICTION = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    input  logic        instr_fault_in,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instr_out
);

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DRAIN, S_HOLD, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_fault_q, hold_fault_d;

    logic        valid_q, exc_q, taken_q;
    logic [3:0]  cause_q;
    logic [31:0] pc_out_q, next_pc_q, instr_q;

    logic        req, misaligned, from_bus, from_hold, complete;
    logic [31:0] addr, comp_instr, b_imm, j_imm, pred_next;
    logic        comp_fault, pred_taken;

    // Request generation; WAIT and DRAIN keep the originally issued address.
    always_comb begin
        req        = 1'b0;
        addr       = pc_q;
        misaligned = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!stall_in && !redirect_in) begin
                    if (pc_q[1:0] == 2'b00) req = 1'b1;
                    else                    misaligned = 1'b1;
                end
            end
            S_WAIT, S_DRAIN: begin
                req  = 1'b1;
                addr = req_addr_q;
            end
            default: ;
        endcase
    end

    assign instr_read_out    = req && !reset;
    assign instr_address_out = reset ? 32'h0 : addr;

    assign from_bus   = ((state_q == S_FETCH) && req && instr_ready_in) ||
                        ((state_q == S_WAIT) && instr_ready_in && !stall_in);
    assign from_hold  = (state_q == S_HOLD) && !stall_in;
    assign complete   = (from_bus || from_hold) && !redirect_in;
    assign comp_instr = from_hold ? hold_instr_q : instr_read_value_in;
    assign comp_fault = from_hold ? hold_fault_q : instr_fault_in;

    assign b_imm = {{20{comp_instr[31]}}, comp_instr[7], comp_instr[30:25], comp_instr[11:8], 1'b0};
    assign j_imm = {{12{comp_instr[31]}}, comp_instr[19:12], comp_instr[20], comp_instr[30:21], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc_q + 32'd4;
        if (BRANCH_PREDICTION) begin
            if (comp_instr[6:0] == 7'b1100011 && comp_instr[31]) begin
                pred_taken = 1'b1;
                pred_next  = pc_q + b_imm;
            end else if (comp_instr[6:0] == 7'b1101111) begin
                pred_taken = 1'b1;
                pred_next  = pc_q + j_imm;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_fault_d = hold_fault_q;
        if (redirect_in) begin
            // An unanswered request must still be drained before fetching the new target.
            pc_d = redirect_pc_in;
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !instr_ready_in) state_d = S_DRAIN;
            else                                                              state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (req && !instr_ready_in) begin
                        state_d    = S_WAIT;
                        req_addr_d = pc_q;
                    end else if (misaligned) begin
                        state_d = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (instr_ready_in && stall_in) begin
                        state_d      = S_HOLD;
                        hold_instr_d = instr_read_value_in;
                        hold_fault_d = instr_fault_in;
                    end
                end
                S_DRAIN: if (instr_ready_in) state_d = S_FETCH;
                default: ;
            endcase
            if (complete) begin
                if (comp_fault) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pred_next;
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_fault_q <= hold_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            exc_q     <= 1'b0;
            cause_q   <= 4'd0;
            taken_q   <= 1'b0;
            pc_out_q  <= 32'h0;
            next_pc_q <= 32'h0;
            instr_q   <= 32'h0;
        end else if (!stall_in) begin
            if (flush_in || !(complete || misaligned)) begin
                valid_q   <= 1'b0;
                exc_q     <= 1'b0;
                cause_q   <= 4'd0;
                taken_q   <= 1'b0;
                pc_out_q  <= 32'h0;
                next_pc_q <= 32'h0;
                instr_q   <= 32'h0;
            end else if (misaligned) begin
                valid_q   <= 1'b0;
                exc_q     <= 1'b1;
                cause_q   <= 4'd0;
                taken_q   <= 1'b0;
                pc_out_q  <= pc_q;
                next_pc_q <= pc_q;
                instr_q   <= 32'h0;
            end else begin
                valid_q   <= !comp_fault;
                exc_q     <= comp_fault;
                cause_q   <= comp_fault ? 4'd1 : 4'd0;
                taken_q   <= !comp_fault && pred_taken;
                pc_out_q  <= pc_q;
                next_pc_q <= pred_next;
                instr_q   <= comp_instr;
            end
        end
    end

    assign valid_out                  = valid_q;
    assign exception_out              = exc_q;
    assign exception_cause_out        = cause_q;
    assign branch_predicted_taken_out = taken_q;
    assign pc_out                     = pc_out_q;
    assign next_pc_out                = next_pc_q;
    assign instr_out                  = instr_q;

endmodule

// File: tb/tb_rv32_fetch.sv
// tb/tb_rv32_fetch.sv - directed and randomized self-checking bench for rv32_fetch
module tb_rv32_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0, flush_in = 1'b0, redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        instr_read_out;
    logic [31:0] instr_address_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] instr_read_value_in = 32'h0;
    logic        instr_fault_in = 1'b0;
    logic        valid_out, exception_out, branch_predicted_taken_out;
    logic [3:0]  exception_cause_out;
    logic [31:0] pc_out, next_pc_out, instr_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem [0:255];

    rv32_fetch dut (
        .clk(clk), .reset(reset),
        .stall_in(stall_in), .flush_in(flush_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .instr_read_out(instr_read_out), .instr_address_out(instr_address_out),
        .instr_ready_in(instr_ready_in), .instr_read_value_in(instr_read_value_in),
        .instr_fault_in(instr_fault_in),
        .valid_out(valid_out), .exception_out(exception_out),
        .exception_cause_out(exception_cause_out),
        .branch_predicted_taken_out(branch_predicted_taken_out),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] dat, input logic flt);
        stall_in            = st;
        flush_in            = 1'b0;
        redirect_in         = rd;
        redirect_pc_in      = rpc;
        instr_ready_in      = rdy;
        instr_read_value_in = dat;
        instr_fault_in      = flt;
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        tick();
        check("rst_read", instr_read_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_exc", exception_out, 0);
        check("rst_pc_out", pc_out, 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Reference prediction: bit 32 = taken, bits 31:0 = next pc.
    function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] ins);
        int off;
        if (ins[6:0] == 7'h63 && ins[31]) begin
            off = -4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            return {1'b1, pc + 32'(off)};
        end
        if (ins[6:0] == 7'h6F) begin
            off = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                  + int'(ins[30:21]) * 2;
            return {1'b1, pc + 32'(off)};
        end
        return {1'b0, pc + 32'd4};
    endfunction

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] im;
        im = 13'(off);
        return {im[12], im[10:5], 5'd1, 5'd2, 3'd0, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] jm;
        jm = 21'(off);
        return {jm[20], jm[10:1], jm[11], jm[19:12], 5'd1, 7'h6F};
    endfunction

    initial begin
        int n8;
        logic [31:0] req_pc, exp_pc, drain_addr, rpc;
        logic [32:0] pn;
        logic outstanding, drain_pending, st, rd, rdy;
        int wait_left, n_bund;

        // zero-wait sequential fetch
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d1_read0", instr_read_out, 1);
        check("d1_addr0", instr_address_out, 32'h0);
        check("d1_valid0", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d1_valid1", valid_out, 1);
        check("d1_pc", pc_out, 32'h0);
        check("d1_next", next_pc_out, 32'h4);
        check("d1_instr", instr_out, 32'h13);
        check("d1_addr4", instr_address_out, 32'h4);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d1_addr8", instr_address_out, 32'h8);
        check("d1_pc4", pc_out, 32'h4);

        // ready delayed three cycles at 0x8
        n8 = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); end
            check("d2_read_held", instr_read_out, 1);
            check("d2_addr_held", instr_address_out, 32'h8);
            if (valid_out && pc_out == 32'h8) n8++;
        end
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d2_addr_ready", instr_address_out, 32'h8);
        if (valid_out && pc_out == 32'h8) n8++;
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            if (valid_out && pc_out == 32'h8) n8++;
        end
        check("d2_one_bundle", n8, 1);

        // backward branch predicted taken
        do_reset();
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        check("d3_no_req_on_redir", instr_read_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFE000EE3, 1'b0);
        check("d3_addr", instr_address_out, 32'h10);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d3_valid", valid_out, 1);
        check("d3_taken", branch_predicted_taken_out, 1);
        check("d3_next", next_pc_out, 32'hC);
        check("d3_next_req", instr_address_out, 32'hC);

        // redirect while a request is pending, plus a second redirect during drain
        do_reset();
        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d4_addr20", instr_address_out, 32'h20);
        tick(); drive(1'b0, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0);
        check("d4_drain_read", instr_read_out, 1);
        check("d4_drain_addr", instr_address_out, 32'h20);
        tick(); drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        check("d4_drain_addr2", instr_address_out, 32'h20);
        check("d4_no_bundle", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d4_drain_done_addr", instr_address_out, 32'h20);
        check("d4_no_bundle2", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d4_new_addr", instr_address_out, 32'h100);
        check("d4_no_bundle3", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d4_valid", valid_out, 1);
        check("d4_pc", pc_out, 32'h100);

        // stall freezing and ready under stall
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        tick(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_stall_no_req", instr_read_out, 0);
        check("d5_valid", valid_out, 1);
        tick(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_frozen_valid", valid_out, 1);
        check("d5_frozen_pc", pc_out, 32'h0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_req4", instr_address_out, 32'h4);
        tick(); drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b0);
        check("d5_req4_held", instr_read_out, 1);
        tick(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_hold_no_req", instr_read_out, 0);
        check("d5_hold_valid", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_release_no_req", instr_read_out, 0);
        check("d5_release_valid", valid_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d5_buf_valid", valid_out, 1);
        check("d5_buf_pc", pc_out, 32'h4);
        check("d5_buf_instr", instr_out, 32'h00A00093);
        check("d5_next_addr", instr_address_out, 32'h8);

        // access fault, then misaligned redirect target
        do_reset();
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b1);
        check("d6_addr40", instr_address_out, 32'h40);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d6_exc", exception_out, 1);
        check("d6_cause", exception_cause_out, 1);
        check("d6_valid", valid_out, 0);
        check("d6_halt_req", instr_read_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("d6_exc_once", exception_out, 0);
        check("d6_halt_req2", instr_read_out, 0);
        tick(); drive(1'b0, 1'b1, 32'h2, 1'b0, 32'h0, 1'b0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d6_mis_no_req", instr_read_out, 0);
        tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
        check("d6_mis_exc", exception_out, 1);
        check("d6_mis_cause", exception_cause_out, 0);
        check("d6_mis_valid", valid_out, 0);
        check("d6_mis_pc", pc_out, 32'h2);
        check("d6_mis_halt", instr_read_out, 0);

        // randomized program with random latency, stalls and redirects
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 4))
                0:       mem[i] = 32'h13;
                1:       mem[i] = enc_b(-4 * int'($urandom_range(1, 8)));
                2:       mem[i] = enc_b(4 * int'($urandom_range(1, 8)));
                3:       mem[i] = enc_j(($urandom_range(0, 1) == 1 ? -4 : 4) * int'($urandom_range(1, 16)));
                default: mem[i] = {$urandom_range(0, 32'h1FFFFFF), 7'h33};
            endcase
        end
        do_reset();
        req_pc = 32'h0; exp_pc = 32'h0; drain_addr = 32'h0;
        outstanding = 1'b0; drain_pending = 1'b0; wait_left = -1; n_bund = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) tick();
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 29) == 0);
            if (rd) st = 1'b0;
            rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            stall_in = st; flush_in = rd; redirect_in = rd; redirect_pc_in = rpc;
            #1;
            rdy = 1'b0;
            if (instr_read_out) begin
                if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
                if (wait_left == 0) begin rdy = 1'b1; wait_left = -1; end
                else wait_left--;
            end else begin
                wait_left = -1;
            end
            instr_ready_in      = rdy;
            instr_read_value_in = rdy ? mem[instr_address_out[9:2]] : $urandom;
            instr_fault_in      = 1'b0;
            #1;
            if (!st) begin
                check("rnd_exc", exception_out, 0);
                if (valid_out) begin
                    pn = model_next(exp_pc, mem[exp_pc[9:2]]);
                    check("rnd_pc", pc_out, exp_pc);
                    check("rnd_instr", instr_out, mem[exp_pc[9:2]]);
                    check("rnd_next", next_pc_out, pn[31:0]);
                    check("rnd_taken", branch_predicted_taken_out, pn[32]);
                    exp_pc = pn[31:0];
                    n_bund++;
                end
            end
            if (outstanding)     check("rnd_req_held", instr_read_out, 1);
            else if (st || rd)   check("rnd_no_req", instr_read_out, 0);
            if (instr_read_out)  check("rnd_addr", instr_address_out, drain_pending ? drain_addr : req_pc);
            if (instr_read_out && rdy) begin
                if (drain_pending) begin
                    drain_pending = 1'b0;
                end else if (!rd) begin
                    pn = model_next(req_pc, mem[req_pc[9:2]]);
                    req_pc = pn[31:0];
                end
            end
            outstanding = instr_read_out && !rdy;
            if (rd) begin
                if (outstanding && !drain_pending) begin
                    drain_pending = 1'b1;
                    drain_addr    = req_pc;
                end
                req_pc = rpc;
                exp_pc = rpc;
            end
        end
        check("rnd_progress", 32'(n_bund >= 300), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
